// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands (CRC7/end-bit checked)
// and returns R1/R3 (48-bit) or R2 (136-bit) responses after an NCR idle gap.
//
// state | meaning
// IDLE  | line released, waiting for a command start bit or a response request
// RX    | shifting in command bits 46..0
// GAP   | response latched, waiting out the NCR gap before the start bit
// TX    | driving response frame bits onto CMD
module sd_card_cmd_responder #(
    parameter int NCR = 2
) (
    input  logic         sd_clk,
    input  logic         rst,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_crc_err,
    input  logic         rsp_req,
    input  logic [1:0]   rsp_type,
    input  logic [5:0]   rsp_index,
    input  logic [31:0]  rsp_arg,
    input  logic [127:0] rsp_cid,
    output logic         rsp_busy,
    output logic         rsp_done
);
    typedef enum logic [1:0] {IDLE, RX, GAP, TX} state_t;

    localparam logic [6:0] GAP_MAX = 7'd127;
    localparam logic [6:0] NCR_CNT = 7'(NCR);
    localparam logic [1:0] RT_R1   = 2'd1;
    localparam logic [1:0] RT_R2   = 2'd2;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [6:0]     crc_q, crc_d;
    logic [45:0]    rx_sr_q, rx_sr_d;
    logic           rx_fin_q, rx_fin_d;
    logic [6:0]     gap_q, gap_d;
    logic [135:0]   tx_sr_q, tx_sr_d;
    logic [1:0]     rt_q, rt_d;
    logic [5:0]     ri_q, ri_d;
    logic [31:0]    ra_q, ra_d;
    logic [126:0]   rc_q, rc_d;
    logic           busy_q, busy_d, done_q, done_d, out_q, out_d, oe_q, oe_d;
    logic           valid_q, valid_d, err_q, err_d;
    logic [5:0]     index_q, index_d;
    logic [31:0]    arg_q, arg_d;
    logic [135:0]   frame_full;
    logic           tx_bit;
    logic           cid_lsb_unused;

    // cid[0] is not part of the R2 frame; the end bit takes its place.
    assign cid_lsb_unused = rsp_cid[0];

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // Left-aligned frame image; the R1 CRC field is zero here and is driven serially during TX.
    always_comb begin
        frame_full = '0;
        case (rt_q)
            RT_R1:   frame_full = {2'b00, ri_q, ra_q, 7'h00, 1'b1, 88'h0};
            RT_R2:   frame_full = {2'b00, 6'h3F, rc_q, 1'b1};
            default: frame_full = {2'b00, 6'h3F, ra_q, 7'h7F, 1'b1, 88'h0};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        rx_sr_d  = rx_sr_q;
        rx_fin_d = 1'b0;
        gap_d    = (gap_q == GAP_MAX) ? GAP_MAX : gap_q + 7'd1;
        tx_sr_d  = tx_sr_q;
        rt_d     = rt_q;
        ri_d     = ri_q;
        ra_d     = ra_q;
        rc_d     = rc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        out_d    = 1'b1;
        oe_d     = 1'b0;
        valid_d  = 1'b0;
        index_d  = index_q;
        arg_d    = arg_q;
        err_d    = err_q;
        tx_bit   = 1'b1;

        if (rx_fin_q) begin
            valid_d = 1'b1;
            index_d = rx_sr_q[45:40];
            arg_d   = rx_sr_q[39:8];
            err_d   = (crc_q != rx_sr_q[7:1]) || !rx_sr_q[0];
        end

        if (rsp_req && !busy_q && state_q != RX && rsp_type != 2'd0) begin
            rt_d    = rsp_type;
            ri_d    = rsp_index;
            ra_d    = rsp_arg;
            rc_d    = rsp_cid[127:1];
            busy_d  = 1'b1;
            state_d = GAP;
        end

        case (state_q)
            IDLE: begin
                if (!cmd_in) begin
                    state_d = RX;
                    cnt_d   = 8'd46;
                    crc_d   = '0;
                end
            end
            RX: begin
                if (cnt_q == 8'd46 && !cmd_in) begin
                    state_d = busy_q ? GAP : IDLE;
                end else begin
                    if (cnt_q != 8'd46) rx_sr_d = {rx_sr_q[44:0], cmd_in};
                    if (cnt_q >= 8'd8) crc_d = crc7_step(crc_q, cmd_in);
                    if (cnt_q == 8'd0) begin
                        rx_fin_d = 1'b1;
                        gap_d    = '0;
                        state_d  = busy_q ? GAP : IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            GAP: begin
                // A host command arriving while a response is pending wins; GAP resumes after it.
                if (!cmd_in) begin
                    state_d = RX;
                    cnt_d   = 8'd46;
                    crc_d   = '0;
                end else if (gap_q >= NCR_CNT) begin
                    state_d = TX;
                    out_d   = 1'b0;
                    oe_d    = 1'b1;
                    tx_sr_d = {frame_full[134:0], 1'b0};
                    cnt_d   = (rt_q == RT_R2) ? 8'd135 : 8'd47;
                    crc_d   = '0;
                end
            end
            TX: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    if (rt_q == RT_R1 && cnt_q <= 8'd8 && cnt_q >= 8'd2) begin
                        tx_bit = crc_q[6];
                        crc_d  = {crc_q[5:0], 1'b0};
                    end else begin
                        tx_bit = tx_sr_q[135];
                        if (rt_q == RT_R1 && cnt_q >= 8'd9) crc_d = crc7_step(crc_q, tx_bit);
                    end
                    tx_sr_d = {tx_sr_q[134:0], 1'b0};
                    cnt_d   = cnt_q - 8'd1;
                    out_d   = tx_bit;
                    oe_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            crc_q    <= '0;
            rx_sr_q  <= '0;
            rx_fin_q <= 1'b0;
            gap_q    <= GAP_MAX;
            tx_sr_q  <= '0;
            rt_q     <= '0;
            ri_q     <= '0;
            ra_q     <= '0;
            rc_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= 1'b1;
            oe_q     <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            index_q  <= '0;
            arg_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            rx_sr_q  <= rx_sr_d;
            rx_fin_q <= rx_fin_d;
            gap_q    <= gap_d;
            tx_sr_q  <= tx_sr_d;
            rt_q     <= rt_d;
            ri_q     <= ri_d;
            ra_q     <= ra_d;
            rc_q     <= rc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            index_q  <= index_d;
            arg_q    <= arg_d;
        end
    end

    assign cmd_out     = out_q;
    assign cmd_oe      = oe_q;
    assign cmd_valid   = valid_q;
    assign cmd_index   = index_q;
    assign cmd_arg     = arg_q;
    assign cmd_crc_err = err_q;
    assign rsp_busy    = busy_q;
    assign rsp_done    = done_q;
endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Self-checking bench for sd_card_cmd_responder: known-frame vector table, hand-written
// corner sequences, and randomized command/response traffic against a polynomial-division model.
module tb_sd_card_cmd_responder;
    logic         sd_clk, rst, cmd_in, rsp_req;
    logic         cmd_out, cmd_oe, cmd_valid, cmd_crc_err, rsp_busy, rsp_done;
    logic [5:0]   cmd_index, rsp_index;
    logic [31:0]  cmd_arg, rsp_arg;
    logic [1:0]   rsp_type;
    logic [127:0] rsp_cid;

    sd_card_cmd_responder #(.NCR(2)) dut (
        .sd_clk(sd_clk), .rst(rst), .cmd_in(cmd_in), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
        .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .cmd_crc_err(cmd_crc_err), .rsp_req(rsp_req), .rsp_type(rsp_type),
        .rsp_index(rsp_index), .rsp_arg(rsp_arg), .rsp_cid(rsp_cid),
        .rsp_busy(rsp_busy), .rsp_done(rsp_done)
    );

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [47:0] frame;
        bit          exp_valid;
        logic [5:0]  idx;
        logic [31:0] arg;
        bit          err;
    } vec_t;

    vec_t vecs[7];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   e_cyc = 0;
    int   oe_cnt = 0;
    int   done_cnt = 0;

    task automatic step();
        @(posedge sd_clk);
        #1;
        cyc++;
        if (cmd_oe) oe_cnt++;
        if (rsp_done) done_cnt++;
    endtask

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_div(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] body;
        body = {2'b01, idx, arg};
        return {body, crc7_div(body), 1'b1};
    endfunction

    function automatic logic [135:0] model_rsp(input int typ, input logic [5:0] idx,
                                               input logic [31:0] arg, input logic [127:0] cid,
                                               output int len);
        logic [39:0] body;
        if (typ == 2) begin
            len = 136;
            return {2'b00, 6'h3F, cid[127:1], 1'b1};
        end
        len = 48;
        if (typ == 1) begin
            body = {2'b00, idx, arg};
            return 136'({body, crc7_div(body), 1'b1});
        end
        return 136'({2'b00, 6'h3F, arg, 7'h7F, 1'b1});
    endfunction

    task automatic send_cmd(input logic [47:0] f, output bit seen, output int off);
        int s;
        seen = 0;
        off  = -1;
        s    = cyc + 1;
        for (int i = 47; i >= 0; i--) begin
            cmd_in = f[i];
            step();
            if (cmd_valid && !seen) begin seen = 1; off = cyc - s; end
        end
        cmd_in = 1'b1;
        e_cyc  = s + 47;
        for (int j = 0; j < 6 && !seen; j++) begin
            step();
            if (cmd_valid) begin seen = 1; off = cyc - s; end
        end
    endtask

    task automatic capture(output logic [135:0] bits, output int len, output int st, output bit dok);
        int b;
        bits = '0; len = 0; st = -1; dok = 0; b = 0;
        while (!cmd_oe && b < 300) begin step(); b++; end
        if (cmd_oe) begin
            st = cyc;
            while (cmd_oe && len < 200) begin
                bits = {bits[134:0], cmd_out};
                len++;
                step();
            end
            dok = rsp_done && !rsp_busy && cmd_out;
        end
    endtask

    task automatic request(input int typ, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [127:0] cid);
        rsp_type  = 2'(typ);
        rsp_index = idx;
        rsp_arg   = arg;
        rsp_cid   = cid;
        rsp_req   = 1'b1;
        step();
        rsp_req   = 1'b0;
    endtask

    initial begin
        bit           seen, dok, corrupt;
        int           off, len, st, a, exp_len, exp_st, typ, d;
        logic [135:0] bits, exp_bits;
        logic [47:0]  f;
        logic [5:0]   ridx;
        logic [31:0]  rarg;
        logic [127:0] rcid;

        vecs[0] = '{48'h40_0000_0000_95, 1'b1, 6'd0,  32'h0,        1'b0};
        vecs[1] = '{48'h48_0000_01AA_87, 1'b1, 6'd8,  32'h0000_01AA, 1'b0};
        vecs[2] = '{48'h48_0000_01AA_89, 1'b1, 6'd8,  32'h0000_01AA, 1'b1};
        vecs[3] = '{48'h48_0000_01AA_86, 1'b1, 6'd8,  32'h0000_01AA, 1'b1};
        vecs[4] = '{48'h3F_FFFF_FFFF_FF, 1'b0, 6'd0,  32'h0,        1'b0};
        vecs[5] = '{48'h77_0000_0000_65, 1'b1, 6'd55, 32'h0,        1'b0};
        vecs[6] = '{48'h69_4000_0000_77, 1'b1, 6'd41, 32'h4000_0000, 1'b0};

        rst = 1'b1; cmd_in = 1'b1; rsp_req = 1'b0; rsp_type = 2'd0;
        rsp_index = '0; rsp_arg = '0; rsp_cid = '0;
        repeat (3) step();
        chk("rst_cmd_out", 136'(cmd_out), 136'(1));
        chk("rst_cmd_oe", 136'(cmd_oe), 136'(0));
        chk("rst_flags", 136'({cmd_valid, rsp_done, rsp_busy, cmd_crc_err}), 136'(0));
        chk("rst_fields", 136'({cmd_index, cmd_arg}), 136'(0));
        rst = 1'b0;
        step();

        // R3 with no prior command: start bit the cycle after acceptance.
        request(3, 6'd0, 32'h00FF_8000, '0);
        a = cyc;
        chk("r3_busy", 136'(rsp_busy), 136'(1));
        capture(bits, len, st, dok);
        chk("r3_frame", bits, 136'(48'h3F00FF8000FF));
        chk("r3_len", 136'(len), 136'(48));
        chk("r3_start", 136'(st), 136'(a + 1));
        chk("r3_done", 136'(dok), 136'(1));

        rcid = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        request(2, 6'd0, 32'h0, rcid);
        capture(bits, len, st, dok);
        exp_bits = model_rsp(2, 6'd0, 32'h0, rcid, exp_len);
        chk("r2_frame", bits, exp_bits);
        chk("r2_first_byte", 136'(bits[135:128]), 136'(8'h3F));
        chk("r2_len", 136'(len), 136'(136));
        chk("r2_done", 136'(dok), 136'(1));

        for (int i = 0; i < 7; i++) begin
            send_cmd(vecs[i].frame, seen, off);
            chk("vec_valid", 136'(seen), 136'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk("vec_latency", 136'(off), 136'(48));
                chk("vec_index", 136'(cmd_index), 136'(vecs[i].idx));
                chk("vec_arg", 136'(cmd_arg), 136'(vecs[i].arg));
                chk("vec_crc_err", 136'(cmd_crc_err), 136'(vecs[i].err));
                step();
                chk("vec_pulse_width", 136'(cmd_valid), 136'(0));
            end
            repeat (5) step();
        end
        chk("fields_hold", 136'({cmd_index, cmd_arg}), 136'({6'd41, 32'h4000_0000}));

        // CMD8, then R1 requested as soon as cmd_valid is seen.
        send_cmd(48'h48_0000_01AA_87, seen, off);
        chk("cmd8_valid", 136'(seen), 136'(1));
        request(1, 6'd8, 32'h0000_01AA, '0);
        capture(bits, len, st, dok);
        chk("r1_cmd8_frame", bits, 136'(48'h08_0000_01AA_13));
        chk("r1_cmd8_start", 136'(st), 136'(e_cyc + 3));
        chk("r1_cmd8_len", 136'(len), 136'(48));
        chk("r1_cmd8_done", 136'(dok), 136'(1));

        // Type 0 is ignored.
        oe_cnt = 0;
        rsp_type = 2'd0; rsp_req = 1'b1;
        repeat (4) step();
        rsp_req = 1'b0;
        chk("type0_busy", 136'(rsp_busy), 136'(0));
        chk("type0_line", 136'(oe_cnt), 136'(0));

        // Request during RX is dropped.
        oe_cnt = 0;
        f = make_cmd(6'd17, 32'h0000_1000);
        rsp_type = 2'd1; rsp_index = 6'd3; rsp_arg = 32'h1234_5678;
        for (int i = 47; i >= 0; i--) begin
            cmd_in  = f[i];
            rsp_req = (i == 25);
            step();
        end
        rsp_req = 1'b0; cmd_in = 1'b1;
        repeat (20) step();
        chk("rx_req_busy", 136'(rsp_busy), 136'(0));
        chk("rx_req_line", 136'(oe_cnt), 136'(0));
        chk("rx_req_cmd", 136'({cmd_index, cmd_arg}), 136'({6'd17, 32'h0000_1000}));

        // Held request: fields changing while busy are ignored, re-accepted after done.
        rsp_type = 2'd1; rsp_index = 6'd13; rsp_arg = 32'hCAFE_0001; rsp_req = 1'b1;
        step();
        rsp_type = 2'd3; rsp_arg = 32'h5555_AAAA;
        capture(bits, len, st, dok);
        exp_bits = model_rsp(1, 6'd13, 32'hCAFE_0001, '0, exp_len);
        chk("hold_first_frame", bits, exp_bits);
        chk("hold_first_done", 136'(dok), 136'(1));
        step();
        chk("hold_reaccept", 136'(rsp_busy), 136'(1));
        rsp_req = 1'b0;
        capture(bits, len, st, dok);
        exp_bits = model_rsp(3, 6'd0, 32'h5555_AAAA, '0, exp_len);
        chk("hold_second_frame", bits, exp_bits);

        // Command arriving in GAP: response stays pending until NCR after its end bit.
        request(1, 6'd7, 32'h0BAD_F00D, '0);
        oe_cnt = 0;
        send_cmd(make_cmd(6'd9, 32'hABCD_0000), seen, off);
        chk("gap_cmd_valid", 136'(seen), 136'(1));
        chk("gap_cmd_arg", 136'(cmd_arg), 136'(32'hABCD_0000));
        chk("gap_no_early_tx", 136'(oe_cnt), 136'(0));
        chk("gap_busy_kept", 136'(rsp_busy), 136'(1));
        capture(bits, len, st, dok);
        exp_bits = model_rsp(1, 6'd7, 32'h0BAD_F00D, '0, exp_len);
        chk("gap_rsp_frame", bits, exp_bits);
        chk("gap_rsp_start", 136'(st), 136'(e_cyc + 3));

        // Reset 20 bits into an R2 response.
        request(2, 6'd0, 32'h0, rcid);
        for (int i = 0; i < 10 && !cmd_oe; i++) step();
        repeat (20) step();
        chk("r2_mid_oe_before_rst", 136'(cmd_oe), 136'(1));
        rst = 1'b1;
        step();
        chk("rst_mid_line", 136'({cmd_oe, cmd_out}), 136'(2'b01));
        chk("rst_mid_flags", 136'({rsp_busy, rsp_done, cmd_valid}), 136'(0));
        rst = 1'b0;
        oe_cnt = 0; done_cnt = 0;
        repeat (160) step();
        chk("rst_mid_abandon", 136'({oe_cnt, done_cnt}), 136'(0));

        // Randomized commands and responses against the model.
        for (int n = 0; n < 20; n++) begin
            ridx    = 6'($urandom_range(0, 63));
            rarg    = $urandom();
            f       = make_cmd(ridx, rarg);
            corrupt = ($urandom_range(0, 3) == 0);
            if (corrupt) f = f ^ (48'd1 << $urandom_range(0, 7));
            send_cmd(f, seen, off);
            chk("rnd_cmd_valid", 136'(seen), 136'(1));
            chk("rnd_cmd_latency", 136'(off), 136'(48));
            chk("rnd_cmd_fields", 136'({cmd_index, cmd_arg}), 136'({ridx, rarg}));
            chk("rnd_cmd_err", 136'(cmd_crc_err), 136'(corrupt));
            d = $urandom_range(1, 4);
            repeat (d - 1) step();
            typ  = $urandom_range(1, 3);
            ridx = 6'($urandom_range(0, 63));
            rarg = $urandom();
            rcid = {$urandom(), $urandom(), $urandom(), $urandom()};
            request(typ, ridx, rarg, rcid);
            a = cyc;
            exp_st = (a + 1 > e_cyc + 3) ? a + 1 : e_cyc + 3;
            capture(bits, len, st, dok);
            exp_bits = model_rsp(typ, ridx, rarg, rcid, exp_len);
            chk("rnd_rsp_frame", bits, exp_bits);
            chk("rnd_rsp_len", 136'(len), 136'(exp_len));
            chk("rnd_rsp_start", 136'(st), 136'(exp_st));
            chk("rnd_rsp_done", 136'(dok), 136'(1));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
